// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler: FSM state encoding,
// lane width, the "no previous lane" marker and counter widths.
package obstacle_scheduler_pkg;

  localparam int unsigned LANE_W    = 2;
  localparam int unsigned GAP_CNT_W = 5;
  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned RAND_W    = 8;

  // Marks "no obstacle spawned yet" so the first pick is never bumped.
  localparam logic [LANE_W-1:0] LANE_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    SPAWN = 2'd2
  } state_t;

endpackage

// File: rtl/obstacle_scheduler_lane_picker.sv
// Combinational lane choice for a new obstacle.
// Ports:
//   rand_bits  in   2  raw random lane bits
//   last_lane  in   2  lane of the previously accepted obstacle (or LANE_NONE)
//   lane_c     out  2  chosen lane, never equal to last_lane
module lane_picker
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES = 3
) (
  input  logic [1:0]        rand_bits,
  input  logic [LANE_W-1:0] last_lane,
  output logic [LANE_W-1:0] lane_c
);

  logic [LANE_W-1:0] cand;

  // Fold out-of-range raw values onto lane 0, then step away from a repeat.
  always_comb begin
    cand   = (32'(rand_bits) >= NUM_LANES) ? '0 : LANE_W'(rand_bits);
    lane_c = cand;
    if (cand == last_lane) begin
      lane_c = (32'(cand) == NUM_LANES - 1) ? '0 : LANE_W'(cand + 1'b1);
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: waits a random number of game ticks, then
// offers one obstacle on a valid/ready handshake and counts acceptances.
// Ports:
//   clk          in   1  system clock
//   reset        in   1  synchronous active-low reset
//   enable       in   1  game running; low returns to IDLE
//   tick         in   1  one-cycle game step pulse
//   rand_in      in   8  free-running random byte
//   spawn_ready  in   1  consumer accepts the offer
//   spawn_valid  out  1  obstacle offered
//   spawn_lane   out  2  lane of the offer
//   spawn_count  out  8  accepted obstacles, wrapping
//   busy         out  1  state is not IDLE
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned MIN_GAP   = 4,
  parameter int unsigned GAP_BITS  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                tick,
  input  logic [RAND_W-1:0]   rand_in,
  input  logic                spawn_ready,
  output logic                spawn_valid,
  output logic [LANE_W-1:0]   spawn_lane,
  output logic [COUNT_W-1:0]  spawn_count,
  output logic                busy
);

  state_t                 state, state_nxt;
  logic [GAP_CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [LANE_W-1:0]      last_lane, last_lane_nxt;
  logic [LANE_W-1:0]      lane_nxt;
  logic [COUNT_W-1:0]     count_nxt;
  logic                   valid_nxt;
  logic                   busy_nxt;
  logic [GAP_CNT_W-1:0]   gap_load_c;
  logic [LANE_W-1:0]      pick_lane_c;

  // Gap reload value: minimum spacing plus a random extra.
  assign gap_load_c = GAP_CNT_W'(MIN_GAP) + GAP_CNT_W'(rand_in[GAP_BITS+1:2]);

  lane_picker #(
    .NUM_LANES (NUM_LANES)
  ) u_lane_picker (
    .rand_bits (rand_in[1:0]),
    .last_lane (last_lane),
    .lane_c    (pick_lane_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    gap_cnt_nxt   = gap_cnt;
    valid_nxt     = spawn_valid;
    lane_nxt      = spawn_lane;
    count_nxt     = spawn_count;
    last_lane_nxt = last_lane;

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = GAP;
          gap_cnt_nxt = gap_load_c;
        end
      end
      GAP: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (tick) begin
          gap_cnt_nxt = gap_cnt - 1'b1;
          if (gap_cnt == GAP_CNT_W'(1)) begin
            state_nxt = SPAWN;
            valid_nxt = 1'b1;
            lane_nxt  = pick_lane_c;
          end
        end
      end
      SPAWN: begin
        // An acceptance completes even if enable drops in the same cycle.
        if (spawn_valid && spawn_ready) begin
          count_nxt     = spawn_count + 1'b1;
          last_lane_nxt = spawn_lane;
          gap_cnt_nxt   = gap_load_c;
          valid_nxt     = 1'b0;
          state_nxt     = GAP;
        end
        if (!enable) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      last_lane   <= LANE_NONE;
      spawn_valid <= 1'b0;
      spawn_lane  <= '0;
      spawn_count <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      gap_cnt     <= gap_cnt_nxt;
      last_lane   <= last_lane_nxt;
      spawn_valid <= valid_nxt;
      spawn_lane  <= lane_nxt;
      spawn_count <= count_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: a behavioural model tracks
// remaining ticks, the pending offer and the counters; a compare process
// checks every cycle, and directed steps pin hand-computed values.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

  localparam int MIN_GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] rand_in = 8'h00;
  logic       spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic [7:0] spawn_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  obstacle_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .rand_in     (rand_in),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_count (spawn_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  bit m_ok = 0;
  bit m_run, m_offer;
  int m_rem, m_lane, m_last, m_count;

  function automatic int pick(input int raw, input int last);
    int c;
    c = (raw == 3) ? 0 : raw;
    return (c == last) ? (c + 1) % 3 : c;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_ok = 1; m_run = 0; m_offer = 0; m_rem = 0;
      m_lane = 0; m_last = 3; m_count = 0;
    end else if (m_offer) begin
      if (spawn_ready) begin
        m_count = (m_count + 1) % 256;
        m_last  = m_lane;
        m_offer = 0;
        m_rem   = MIN_GAP + ((int'(rand_in) >> 2) & 7);
      end
      if (!enable) begin
        m_run = 0; m_offer = 0;
      end
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1;
        m_rem = MIN_GAP + ((int'(rand_in) >> 2) & 7);
      end
    end else if (!enable) begin
      m_run = 0;
    end else if (tick) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_offer = 1;
        m_lane  = pick(int'(rand_in) & 3, m_last);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("cyc_valid", 32'(spawn_valid), 32'(m_offer));
      chk("cyc_busy",  32'(busy),        32'(m_run));
      chk("cyc_count", 32'(spawn_count), 32'(m_count));
      chk("cyc_lane",  32'(spawn_lane),  32'(m_lane));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // n tick pulses; returns right after the edge that sampled the last tick
  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b0; step();
      tick = 1'b1; step();
    end
    tick = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with enable high
    reset = 1'b0; enable = 1'b1; rand_in = 8'h00; spawn_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(spawn_valid), 0);
    chk("rst_count", 32'(spawn_count), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_lane",  32'(spawn_lane), 0);
    reset = 1'b1; step();
    chk("busy_after_release", 32'(busy), 1);

    // G=4 from rand 0: three ticks are not enough, the fourth offers lane 0
    ticks(3);
    chk("gap4_not_yet", 32'(spawn_valid), 0);
    ticks(1);
    chk("gap4_valid", 32'(spawn_valid), 1);
    chk("gap4_lane",  32'(spawn_lane), 0);
    step();
    chk("accept1_count", 32'(spawn_count), 1);
    chk("accept1_valid", 32'(spawn_valid), 0);

    // Repeat avoidance: raw 0 after lane 0 -> lane 1
    ticks(4);
    chk("repeat_lane", 32'(spawn_lane), 1);
    rand_in = 8'h1F; step();
    chk("accept2_count", 32'(spawn_count), 2);

    // G = 4 + 7 = 11; raw 3 folds to 0 (last lane 1)
    ticks(10);
    chk("gap11_not_yet", 32'(spawn_valid), 0);
    ticks(1);
    chk("gap11_valid", 32'(spawn_valid), 1);
    chk("gap11_lane",  32'(spawn_lane), 0);
    rand_in = 8'h03; step();
    chk("accept3_count", 32'(spawn_count), 3);

    // raw 3 folds to 0, equals last lane 0 -> lane 1; consumer stalls
    spawn_ready = 1'b0;
    ticks(4);
    chk("stall_valid0", 32'(spawn_valid), 1);
    chk("stall_lane0",  32'(spawn_lane), 1);
    for (int i = 0; i < 20; i++) begin
      tick = i[0];
      rand_in = 8'($urandom);
      step();
      chk("stall_valid", 32'(spawn_valid), 1);
      chk("stall_lane",  32'(spawn_lane), 1);
      chk("stall_count", 32'(spawn_count), 3);
    end
    tick = 1'b0; rand_in = 8'h00; spawn_ready = 1'b1; step();
    chk("stall_accept_count", 32'(spawn_count), 4);

    // enable dropped during an unaccepted offer
    spawn_ready = 1'b0;
    ticks(4);
    chk("drop_offer_lane", 32'(spawn_lane), 0);
    enable = 1'b0; step();
    chk("drop_busy",  32'(busy), 0);
    chk("drop_valid", 32'(spawn_valid), 0);
    chk("drop_count", 32'(spawn_count), 4);

    // enable dropped together with acceptance
    enable = 1'b1; step();
    chk("reenable_busy", 32'(busy), 1);
    ticks(4);
    chk("drop_acc_lane", 32'(spawn_lane), 0);
    enable = 1'b0; spawn_ready = 1'b1; step();
    chk("drop_acc_count", 32'(spawn_count), 5);
    chk("drop_acc_busy",  32'(busy), 0);
    step();
    chk("idle_stays", 32'(busy), 0);

    // 256 acceptances wrap the counter back to its start value
    enable = 1'b1; tick = 1'b1; spawn_ready = 1'b1; rand_in = 8'h00;
    for (int k = 0; k < 256; k++) begin
      n = 0;
      while (!spawn_valid && n < 40) begin
        step();
        n++;
      end
      if (!spawn_valid) begin
        chk("wait_valid_timeout", 0, 1);
        break;
      end
      step();
      if (k == 250) chk("wrap_zero", 32'(spawn_count), 0);
    end
    chk("wrap_full", 32'(spawn_count), 5);

    // Reset during an offer drops it and clears the count
    spawn_ready = 1'b0;
    n = 0;
    while (!spawn_valid && n < 40) begin
      step();
      n++;
    end
    chk("pre_reset_valid", 32'(spawn_valid), 1);
    reset = 1'b0; spawn_ready = 1'b1; step();
    chk("midrst_valid", 32'(spawn_valid), 0);
    chk("midrst_count", 32'(spawn_count), 0);
    chk("midrst_busy",  32'(busy), 0);
    reset = 1'b1; enable = 1'b0; tick = 1'b0; step();
    chk("post_rst_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
